// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : uart_rx_pkg                                                    |
// | Purpose : Shared constants and types for the uart_rx_avalon receiver.    |
// |           Avalon register addresses, STATUS/DATA bit positions and the   |
// |           receive FSM state type.                                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package uart_rx_pkg;

  // Avalon register map
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CLEAR  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // Bit positions inside DATA / STATUS read words
  localparam int DATA_VALID_BIT  = 8;
  localparam int STAT_EMPTY_BIT  = 16;
  localparam int STAT_FULL_BIT   = 17;
  localparam int STAT_FERR_BIT   = 18;
  localparam int STAT_OVR_BIT    = 19;

  // Receive FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_avalon_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : uart_rx_avalon_if                                            |
// | Purpose   : Avalon-MM slave bus plus interrupt line of uart_rx_avalon.   |
// | Ports     : avs_address[1:0], avs_read, avs_write, avs_writedata[31:0]   |
// |             (master -> slave); avs_readdata[31:0], irq (slave -> master) |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface uart_rx_avalon_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_avalon_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sync_fifo                                                      |
// | Purpose : Single-clock FIFO with combinational head output.              |
// | Ports   : push/din write side, pop/dout read side, count/empty/full.     |
// |           A push in the same cycle as a pop is judged against the        |
// |           post-pop occupancy, so it succeeds even when full.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage carries no reset; only pointer-qualified entries are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end
endmodule
`default_nettype wire

// File: rtl/uart_rx_avalon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_rx_avalon                                                 |
// | Purpose : 8N1 UART receiver feeding a byte FIFO read over Avalon-MM.     |
// | Ports   : clk, reset_n (async, active-low), rxd (async serial input),    |
// |           bus (uart_rx_avalon_if.slave: registers + level irq).          |
// | Regs    : 0 DATA (pop), 1 STATUS, 2 CLEAR (w1c ferr/ovr), 3 CTRL (ie).   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_avalon
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rxd,
  uart_rx_avalon_if.slave         bus
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] C_BIT  = CW'(DIV - 1);

  // Synchroniser and receive datapath
  logic            r_sync1, r_sync2;
  logic            w_rxs;
  rx_state_t       r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [2:0]      r_idx, w_idx_nx;
  logic [7:0]      r_shift, w_shift_nx;
  logic            r_brk, w_brk_nx;
  logic            w_push, w_ferr_evt;

  // Register file
  logic            r_ferr, r_ovr, r_ie, r_irq;
  logic [31:0]     r_rdata, w_rdata;
  logic            w_pop, w_ovr_evt, w_clr_ferr, w_clr_ovr;
  logic [7:0]      w_head;
  logic [AW:0]     w_count;
  logic            w_empty, w_full;
  logic            w_unused_wdata;

  assign w_rxs = r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_brk   <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_brk   <= w_brk_nx;
    end
  end

  // r_brk blocks re-arming after a framing error until the line has been
  // seen high again, so a held-low (break) line errors only one frame.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_brk_nx   = r_brk;
    w_push     = 1'b0;
    w_ferr_evt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rxs) begin
          w_brk_nx = 1'b0;
        end else if (!r_brk) begin
          w_cnt_nx   = C_HALF;
          w_state_nx = START;
        end
      end
      START: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else if (w_rxs) begin
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx   = C_BIT;
          w_idx_nx   = '0;
          w_state_nx = DATA;
        end
      end
      DATA: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else begin
          w_shift_nx = {w_rxs, r_shift[7:1]};
          w_cnt_nx   = C_BIT;
          w_idx_nx   = r_idx + 1'b1;
          if (r_idx == 3'd7) w_state_nx = STOP;
        end
      end
      STOP: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else begin
          if (w_rxs) begin
            w_push = 1'b1;
          end else begin
            w_ferr_evt = 1'b1;
            w_brk_nx   = 1'b1;
          end
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (r_shift),
    .dout    (w_head),
    .count   (w_count),
    .empty   (w_empty),
    .full    (w_full)
  );

  assign w_pop      = bus.avs_read && (bus.avs_address == ADDR_DATA) && !w_empty;
  // A push that the FIFO refuses: full and not relieved by a same-cycle pop.
  assign w_ovr_evt  = w_push && w_full && !w_pop;
  assign w_clr_ferr = bus.avs_write && (bus.avs_address == ADDR_CLEAR) && bus.avs_writedata[0];
  assign w_clr_ovr  = bus.avs_write && (bus.avs_address == ADDR_CLEAR) && bus.avs_writedata[1];
  assign w_unused_wdata = ^bus.avs_writedata[31:2];

  always_comb begin
    w_rdata = '0;
    unique case (bus.avs_address)
      ADDR_DATA: begin
        if (!w_empty) begin
          w_rdata[DATA_VALID_BIT] = 1'b1;
          w_rdata[7:0]            = w_head;
        end
      end
      ADDR_STATUS: begin
        w_rdata[AW:0]           = w_count;
        w_rdata[STAT_EMPTY_BIT] = w_empty;
        w_rdata[STAT_FULL_BIT]  = w_full;
        w_rdata[STAT_FERR_BIT]  = r_ferr;
        w_rdata[STAT_OVR_BIT]   = r_ovr;
      end
      ADDR_CTRL: w_rdata[0] = r_ie;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_ie    <= 1'b0;
      r_irq   <= 1'b0;
      r_rdata <= '0;
    end else begin
      // Error events take priority over a coincident clear.
      r_ferr  <= w_ferr_evt | (r_ferr & ~w_clr_ferr);
      r_ovr   <= w_ovr_evt  | (r_ovr  & ~w_clr_ovr);
      if (bus.avs_write && (bus.avs_address == ADDR_CTRL)) r_ie <= bus.avs_writedata[0];
      r_irq   <= r_ie & (~w_empty | r_ferr | r_ovr);
      r_rdata <= bus.avs_read ? w_rdata : 32'd0;
    end
  end

  assign bus.avs_readdata = r_rdata;
  assign bus.irq          = r_irq;
endmodule
`default_nettype wire
